dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port access controller that shares the single 32-bit byte-lane data memory between the CPU load/store port (m0) and the DMA/debug port (m1). It arbitrates round-robin and converts byte/half/word requests into a word address, a 4-bit lane select and lane-positioned write data. Load data is extracted and zero- or sign-extended. It sits between the pipeline MEM stage / DMA engine and the data memory.

Parameters:
ADDR_WIDTH, 10, word-address width of data memory (byte address is ADDR_WIDTH+2 bits)
DATA_WIDTH, 32, data width; only 32 supported

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
m0_req  input  1  CPU request; held with fields stable until m0_ack
m0_we  input  1  1=store, 0=load
m0_addr  input  ADDR_WIDTH+2  byte address
m0_size  input  2  00 byte, 01 half, 10 word, 11 illegal
m0_sext  input  1  sign-extend load result
m0_wdata  input  32  store data, right-justified
m0_ack  output  1  one-cycle completion pulse
m0_err  output  1  misaligned/illegal, valid with m0_ack
m0_rdata  output  32  load result, valid with m0_ack
m1_*  same set as m0_* for DMA port
mem_A  output  ADDR_WIDTH  word address to memory
mem_inD  output  32  lane-positioned write data
mem_sel  output  4  byte-lane select
mem_str  output  1  write strobe (memory writes on clk edge when high)
mem_outD  input  32  full word read from memory, combinational from mem_A

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset: state=IDLE, last_grant=1, all outputs 0 (mem_A, mem_inD, mem_sel, mem_str, both ack/err/rdata).
- IDLE: if any req, register the winner's fields and move to ACCESS; else stay.
- Round-robin arbitration: with one request, grant it. With both, grant the port not equal to last_grant, then update last_grant. After reset, m0 wins the first tie.
- ACCESS (1 cycle): drive mem_A = addr[ADDR_WIDTH+1:2].
  - Store: mem_str=1 and mem_sel = lane mask. Byte: 0001<<addr[1:0]. Half: 0011 if addr[1]=0, 1100 if addr[1]=1. Word: 1111.
  - Store data: mem_inD replicates data across lanes (byte x4, half x2, word as-is).
  - Load: mem_str=0, mem_sel=1111, and mem_outD is captured at the end of ACCESS.
  - Then go to RESP.
- RESP (1 cycle): pulse the granted port's ack for exactly one cycle.
  - rdata: byte = mem_outD lane addr[1:0]; half = lane pair addr[1]. Zero-extend, or sign-extend when sext=1.
  - Store response: rdata=0.
  - The ungranted port's ack/err/rdata stay 0.
  - mem_str and mem_sel return to 0. Go to IDLE.
- Latency: req seen in IDLE at cycle N leads to the memory cycle at N+1 and ack at N+2. Throughput is one access per 3 cycles.
- Misaligned or illegal requests: half with addr[0]=1, word with addr[1:0]!=0, or size=11. mem_str stays 0 and mem_sel=0 during ACCESS, so there is no memory side effect. Ack fires with err=1, rdata=0, same latency.
- Requester holds req; a request still high in the IDLE cycle after its ack is treated as a new request.
- Request arriving in ACCESS/RESP is not sampled until IDLE. A request dropped before grant is simply lost; no error is raised.
- rst asserted in any state: next edge forces IDLE, clears mem_str, and suppresses any pending ack. A store in ACCESS at the reset edge is not guaranteed.
- Requests presented in ACCESS/RESP are not buffered; no queue.

Test Plan:
- Reset then m0 word store addr=0x008, wdata=0xDEADBEEF. Required: at N+1 mem_A=2, mem_sel=1111, mem_str=1, mem_inD=0xDEADBEEF; at N+2 m0_ack=1, err=0.
- m0 byte load addr=0x00B, sext=1, memory word 0x80FF_1234. Required: mem_sel=1111, m0_rdata=0xFFFFFF80. Repeat with sext=0: rdata=0x00000080.
- m1 half store addr=0x006, wdata=0x0000ABCD. Required: mem_A=1, mem_sel=1100, mem_inD=0xABCDABCD, str pulse 1 cycle.
- m0 and m1 both request continuously from reset. Required grants alternate m0,m1,m0,m1; acks 3 cycles apart; never both acks together.
- m0 word load addr=0x002. Required: no mem_str, mem_sel=0000 in ACCESS, m0_ack=1, m0_err=1, rdata=0 at N+2.
- Assert rst during ACCESS of an m1 load. Required: next cycle state IDLE, mem_str=0, no m1_ack; the following m1 request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one byte-lane data memory between the CPU (m0) and DMA (m1) ports.
// It converts byte/half/word requests into lane selects and returns aligned, extended load data.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH+1:0] m0_addr,
    input  logic [1:0]            m0_size,
    input  logic                  m0_sext,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH+1:0] m1_addr,
    input  logic [1:0]            m1_size,
    input  logic                  m1_sext,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_inD,
    output logic [3:0]            mem_sel,
    output logic                  mem_str,
    input  logic [DATA_WIDTH-1:0] mem_outD
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic                  last_grant;
    logic                  gnt;
    logic                  r_we;
    logic                  r_sext;
    logic                  r_bad;
    logic [1:0]            r_addr;
    logic [1:0]            r_size;

    logic                  pick;
    logic                  s_we;
    logic                  s_sext;
    logic [ADDR_WIDTH+1:0] s_addr;
    logic [1:0]            s_size;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_bad;
    logic [3:0]            s_mask;
    logic [DATA_WIDTH-1:0] s_rep;

    logic [7:0]            ld_b;
    logic [15:0]           ld_h;
    logic [DATA_WIDTH-1:0] ld;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        pick    = (m0_req && m1_req) ? ~last_grant : ~m0_req;
        s_we    = pick ? m1_we    : m0_we;
        s_sext  = pick ? m1_sext  : m0_sext;
        s_addr  = pick ? m1_addr  : m0_addr;
        s_size  = pick ? m1_size  : m0_size;
        s_wdata = pick ? m1_wdata : m0_wdata;
        s_bad   = 1'b0;
        s_mask  = 4'b1111;
        s_rep   = s_wdata;
        case (s_size)
            2'b00: begin
                s_mask = 4'b0001 << s_addr[1:0];
                s_rep  = {4{s_wdata[7:0]}};
            end
            2'b01: begin
                s_bad  = s_addr[0];
                s_mask = s_addr[1] ? 4'b1100 : 4'b0011;
                s_rep  = {2{s_wdata[15:0]}};
            end
            2'b10:   s_bad = |s_addr[1:0];
            default: s_bad = 1'b1;
        endcase
    end

    always_comb begin
        ld_b = mem_outD[{r_addr, 3'b000} +: 8];
        ld_h = mem_outD[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   ld = {{24{r_sext & ld_b[7]}}, ld_b};
            2'b01:   ld = {{16{r_sext & ld_h[15]}}, ld_h};
            default: ld = mem_outD;
        endcase
        if (r_we || r_bad) ld = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            r_we       <= 1'b0;
            r_sext     <= 1'b0;
            r_bad      <= 1'b0;
            r_addr     <= '0;
            r_size     <= '0;
            mem_A      <= '0;
            mem_inD    <= '0;
            mem_sel    <= '0;
            mem_str    <= 1'b0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt        <= pick;
                        last_grant <= pick;
                        r_we       <= s_we;
                        r_sext     <= s_sext;
                        r_bad      <= s_bad;
                        r_addr     <= s_addr[1:0];
                        r_size     <= s_size;
                        mem_A      <= s_addr[ADDR_WIDTH+1:2];
                        mem_inD    <= s_rep;
                        // Illegal requests touch no lanes, so memory is left untouched.
                        mem_sel    <= s_bad ? 4'b0000 : (s_we ? s_mask : 4'b1111);
                        mem_str    <= s_we && !s_bad;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_str  <= 1'b0;
                    mem_sel  <= '0;
                    m0_ack   <= ~gnt;
                    m0_err   <= ~gnt & r_bad;
                    m0_rdata <= gnt ? '0 : ld;
                    m1_ack   <= gnt;
                    m1_err   <= gnt & r_bad;
                    m1_rdata <= gnt ? ld : '0;
                    state    <= RESP;
                end
                RESP: begin
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m0_rdata <= '0;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    m1_rdata <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
